// File: rtl/uart_cmd_pkg.sv
// Shared constants and FSM state type for the UART command slave.
// Opcodes, response bytes and the frame-decoder state enum live here.
package uart_cmd_pkg;

    localparam logic [7:0] OpWrite = 8'h57;
    localparam logic [7:0] OpRead  = 8'h52;
    localparam logic [7:0] RespAck = 8'h4B;
    localparam logic [7:0] RespErr = 8'h45;

    typedef enum logic [2:0] {
        StIdle,
        StGetAddr,
        StGetData,
        StExec,
        StSend,
        StWaitDone
    } state_e;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OpWrite) || (b == OpRead);
    endfunction

endpackage

// File: rtl/uart_cmd_regfile.sv
// NUM_REGS x 8 register file: synchronous write, combinational read,
// asynchronous active-low clear.
module uart_cmd_regfile #(
    parameter int unsigned NUM_REGS = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [$clog2(NUM_REGS)-1:0] wr_addr,
    input  logic [7:0]                  wr_data,
    input  logic [$clog2(NUM_REGS)-1:0] rd_addr,
    output logic [7:0]                  rd_data,
    output logic [7:0]                  reg0
);

    logic [7:0] regs_q [NUM_REGS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (wr_en) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = regs_q[rd_addr];
    assign reg0    = regs_q[0];

endmodule

// File: rtl/uart_cmd_slave.sv
// Byte-level command decoder: 'W' addr data / 'R' addr frames from a UART
// receiver, one response byte per frame handed to a UART transmitter.
module uart_cmd_slave
    import uart_cmd_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT  = 868,
    parameter int unsigned TIMEOUT_BITS = 40,
    parameter int unsigned NUM_REGS     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx_byte_valid,
    input  logic [7:0]                  rx_byte_data,
    input  logic                        par_error,
    input  logic                        stop_error,
    output logic                        tx_byte_valid,
    output logic [7:0]                  tx_byte_data,
    input  logic                        tx_active,
    input  logic                        tx_done,
    output logic                        reg_wr_stb,
    output logic [$clog2(NUM_REGS)-1:0] reg_wr_addr,
    output logic [7:0]                  reg_wr_data,
    output logic [7:0]                  reg0_q,
    output logic                        rx_overrun
);

    localparam int unsigned AddrW         = $clog2(NUM_REGS);
    localparam int unsigned TimeoutCycles = CLK_PER_BIT * TIMEOUT_BITS;
    localparam int unsigned TmoW          = $clog2(TimeoutCycles + 1);

    state_e          state_q, state_d;
    logic            is_wr_q, is_wr_d;
    logic            err_q, err_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      data_q, data_d;
    logic            tx_valid_q, tx_valid_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            overrun_q, overrun_d;
    logic [TmoW-1:0] tmo_q, tmo_d;

    logic            wr_en;
    logic            rx_bad;
    logic            addr_ok;
    logic [7:0]      rd_data;

    assign rx_bad  = par_error | stop_error;
    assign addr_ok = 32'(addr_q) < NUM_REGS;

    uart_cmd_regfile #(
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (addr_q[AddrW-1:0]),
        .wr_data (data_q),
        .rd_addr (addr_q[AddrW-1:0]),
        .rd_data (rd_data),
        .reg0    (reg0_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            is_wr_q    <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= 8'h00;
            data_q     <= 8'h00;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            overrun_q  <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            is_wr_q    <= is_wr_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            overrun_q  <= overrun_d;
            tmo_q      <= tmo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        is_wr_d    = is_wr_q;
        err_d      = err_q;
        addr_d     = addr_q;
        data_d     = data_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        overrun_d  = overrun_q;
        tmo_d      = tmo_q;
        wr_en      = 1'b0;

        if (rx_byte_valid) begin
            tmo_d = TmoW'(TimeoutCycles);
        end else if (tmo_q != '0) begin
            tmo_d = tmo_q - TmoW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (rx_byte_valid) begin
                    err_d = 1'b0;
                    if (!rx_bad && is_opcode(rx_byte_data)) begin
                        is_wr_d = (rx_byte_data == OpWrite);
                        state_d = StGetAddr;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StExec;
                    end
                end
            end
            StGetAddr: begin
                if (rx_byte_valid) begin
                    addr_d = rx_byte_data;
                    if (rx_bad) begin
                        err_d   = 1'b1;
                        state_d = StExec;
                    end else begin
                        state_d = is_wr_q ? StGetData : StExec;
                    end
                end else if (tmo_q == '0) begin
                    state_d = StIdle;
                end
            end
            StGetData: begin
                if (rx_byte_valid) begin
                    data_d  = rx_byte_data;
                    err_d   = rx_bad;
                    state_d = StExec;
                end else if (tmo_q == '0) begin
                    state_d = StIdle;
                end
            end
            StExec: begin
                if (err_q || !addr_ok) begin
                    tx_data_d = RespErr;
                end else if (is_wr_q) begin
                    wr_en     = 1'b1;
                    tx_data_d = RespAck;
                end else begin
                    tx_data_d = rd_data;
                end
                tx_valid_d = 1'b1;
                state_d    = StSend;
            end
            StSend: begin
                if (tx_active) begin
                    tx_valid_d = 1'b0;
                    state_d    = StWaitDone;
                end
            end
            StWaitDone: begin
                if (tx_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Bytes arriving while a response is outstanding are dropped, not queued.
        if (rx_byte_valid && (state_q inside {StExec, StSend, StWaitDone})) begin
            overrun_d = 1'b1;
        end
    end

    assign tx_byte_valid = tx_valid_q;
    assign tx_byte_data  = tx_data_q;
    assign reg_wr_stb    = wr_en;
    assign reg_wr_addr   = addr_q[AddrW-1:0];
    assign reg_wr_data   = data_q;
    assign rx_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_cmd_slave.sv
// Scoreboard bench for uart_cmd_slave: directed frames push expected responses
// and writes; a monitor with a simple transmitter model pops and compares.
module tb_uart_cmd_slave;

    localparam int unsigned NumRegs = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_byte_valid = 1'b0;
    logic [7:0] rx_byte_data = 8'h00;
    logic       par_error = 1'b0;
    logic       stop_error = 1'b0;
    logic       tx_byte_valid;
    logic [7:0] tx_byte_data;
    logic       tx_active = 1'b0;
    logic       tx_done = 1'b0;
    logic       reg_wr_stb;
    logic [3:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic [7:0] reg0_q;
    logic       rx_overrun;

    uart_cmd_slave #(
        .CLK_PER_BIT  (8),
        .TIMEOUT_BITS (4),
        .NUM_REGS     (NumRegs)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_byte_valid (rx_byte_valid),
        .rx_byte_data  (rx_byte_data),
        .par_error     (par_error),
        .stop_error    (stop_error),
        .tx_byte_valid (tx_byte_valid),
        .tx_byte_data  (tx_byte_data),
        .tx_active     (tx_active),
        .tx_done       (tx_done),
        .reg_wr_stb    (reg_wr_stb),
        .reg_wr_addr   (reg_wr_addr),
        .reg_wr_data   (reg_wr_data),
        .reg0_q        (reg0_q),
        .rx_overrun    (rx_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_rsp_q[$];
    logic [11:0] exp_wr_q[$];
    int          last_rx_cyc = 0;
    int          tx_phase = 0;
    int          tx_cnt = 0;
    logic        tx_stall = 1'b0;
    logic        prev_valid = 1'b0;
    logic [7:0]  tx_held = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor and transmitter model, sampled on the falling edge.
    initial begin : monitor
        logic [11:0] we;
        logic [7:0]  er;
        forever begin
            @(negedge clk);
            if (!rst) begin
                tx_phase   = 0;
                tx_active  = 1'b0;
                tx_done    = 1'b0;
                prev_valid = 1'b0;
                continue;
            end
            tx_done = 1'b0;
            if (reg_wr_stb) begin
                if (exp_wr_q.size() == 0) begin
                    check("unexpected_write", {20'h0, reg_wr_addr, reg_wr_data}, 32'hFFFFFFFF);
                end else begin
                    we = exp_wr_q.pop_front();
                    check("wr_addr_data", {20'h0, reg_wr_addr, reg_wr_data}, {20'h0, we});
                    check("wr_latency", cyc - last_rx_cyc, 1);
                end
            end
            if (tx_byte_valid && !prev_valid) begin
                if (exp_rsp_q.size() == 0) begin
                    check("unexpected_response", {24'h0, tx_byte_data}, 32'hFFFFFFFF);
                end else begin
                    er = exp_rsp_q.pop_front();
                    check("response", {24'h0, tx_byte_data}, {24'h0, er});
                    check("tx_latency", cyc - last_rx_cyc, 2);
                end
                tx_held  = tx_byte_data;
                tx_phase = 1;
                tx_cnt   = 0;
            end else if (tx_phase == 1) begin
                check("tx_hold", {23'h0, tx_byte_valid, tx_byte_data}, {23'h0, 1'b1, tx_held});
                tx_cnt++;
                if (tx_cnt >= 2 && !tx_stall) begin
                    tx_active = 1'b1;
                    tx_phase  = 2;
                    tx_cnt    = 0;
                end
            end else if (tx_phase == 2) begin
                if (tx_cnt == 0) check("tx_drop", {31'h0, tx_byte_valid}, 0);
                tx_cnt++;
                if (tx_cnt == 6) begin
                    tx_active = 1'b0;
                    tx_done   = 1'b1;
                    tx_phase  = 0;
                end
            end
            prev_valid = tx_byte_valid;
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic pe, input logic se);
        @(posedge clk);
        #1;
        rx_byte_valid = 1'b1;
        rx_byte_data  = d;
        par_error     = pe;
        stop_error    = se;
        last_rx_cyc   = cyc;
        @(posedge clk);
        #1;
        rx_byte_valid = 1'b0;
        par_error     = 1'b0;
        stop_error    = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_rsp_q.size() != 0 || tx_phase != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (n >= 300) check({name, "_timeout"}, 1, 0);
        repeat (3) @(posedge clk);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d,
                            input logic [7:0] rsp, input logic writes);
        if (writes) exp_wr_q.push_back({a[3:0], d});
        exp_rsp_q.push_back(rsp);
        send_byte(8'h57, 1'b0, 1'b0);
        send_byte(a, 1'b0, 1'b0);
        send_byte(d, 1'b0, 1'b0);
        wait_idle("write");
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] rsp);
        exp_rsp_q.push_back(rsp);
        send_byte(8'h52, 1'b0, 1'b0);
        send_byte(a, 1'b0, 1'b0);
        wait_idle("read");
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1);
    end

    initial begin : stim
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", {31'h0, tx_byte_valid}, 0);
        check("rst_tx_data", {24'h0, tx_byte_data}, 0);
        check("rst_wr_stb", {31'h0, reg_wr_stb}, 0);
        check("rst_wr_addr_data", {20'h0, reg_wr_addr, reg_wr_data}, 0);
        check("rst_reg0", {24'h0, reg0_q}, 0);
        check("rst_overrun", {31'h0, rx_overrun}, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        do_write(8'h03, 8'hA5, 8'h4B, 1'b1);
        do_read(8'h03, 8'hA5);
        do_read(8'h05, 8'h00);
        do_write(8'h00, 8'h3C, 8'h4B, 1'b1);
        #1 check("reg0_after_write", {24'h0, reg0_q}, 32'h3C);
        do_read(8'h20, 8'h45);
        do_write(8'h10, 8'h55, 8'h45, 1'b0);
        do_write(8'h0F, 8'h5A, 8'h4B, 1'b1);
        do_read(8'h0F, 8'h5A);

        // Non-command byte, then an opcode with a parity error.
        exp_rsp_q.push_back(8'h45);
        send_byte(8'h11, 1'b0, 1'b0);
        wait_idle("bad_byte");
        exp_rsp_q.push_back(8'h45);
        send_byte(8'h57, 1'b1, 1'b0);
        wait_idle("par_err");

        // Framing error on the data byte aborts the write.
        exp_rsp_q.push_back(8'h45);
        send_byte(8'h57, 1'b0, 1'b0);
        send_byte(8'h06, 1'b0, 1'b0);
        send_byte(8'h99, 1'b0, 1'b1);
        wait_idle("stop_err");
        do_read(8'h06, 8'h00);

        // Stalled frame times out (32 cycles) and is dropped silently.
        send_byte(8'h57, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        repeat (45) @(posedge clk);
        do_read(8'h02, 8'h00);

        // A gap shorter than the timeout keeps the frame alive.
        exp_wr_q.push_back({4'h4, 8'h77});
        exp_rsp_q.push_back(8'h4B);
        send_byte(8'h57, 1'b0, 1'b0);
        send_byte(8'h04, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        send_byte(8'h77, 1'b0, 1'b0);
        wait_idle("slow_write");

        // Byte during WAIT_DONE is dropped and flags overrun.
        #1 check("overrun_clear", {31'h0, rx_overrun}, 0);
        exp_rsp_q.push_back(8'hA5);
        send_byte(8'h52, 1'b0, 1'b0);
        send_byte(8'h03, 1'b0, 1'b0);
        n = 0;
        while (!tx_active && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("tx_active_seen", {31'h0, tx_active}, 1);
        send_byte(8'h57, 1'b0, 1'b0);
        wait_idle("overrun");
        #1 check("overrun_set", {31'h0, rx_overrun}, 1);
        do_read(8'h04, 8'h77);

        // Reset while the response is being offered.
        tx_stall = 1'b1;
        exp_rsp_q.push_back(8'h3C);
        send_byte(8'h52, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        n = 0;
        while (!tx_byte_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("send_rst_tx_valid", {31'h0, tx_byte_valid}, 0);
        check("send_rst_tx_data", {24'h0, tx_byte_data}, 0);
        check("send_rst_reg0", {24'h0, reg0_q}, 0);
        check("send_rst_overrun", {31'h0, rx_overrun}, 0);
        tx_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (10) @(posedge clk);

        // Reset mid-frame: the following byte starts a fresh frame.
        send_byte(8'h57, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        exp_rsp_q.push_back(8'h45);
        send_byte(8'h01, 1'b0, 1'b0);
        wait_idle("frame_rst");
        do_read(8'h03, 8'h00);
        do_read(8'h01, 8'h00);

        repeat (5) @(posedge clk);
        check("wr_queue_empty", exp_wr_q.size(), 0);
        check("rsp_queue_empty", exp_rsp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
